// File: rtl/data_mem_access_unit_if.sv
// CPU-side request/response and Memoria64-side bus of the data memory access unit.
interface data_mem_access_unit_if;
    logic        req;
    logic        req_write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [63:0] rdata;
    logic [63:0] mem_raddress;
    logic [63:0] mem_waddress;
    logic [63:0] mem_datain;
    logic        mem_wr;
    logic [63:0] mem_dataout;

    modport slave (
        input  req, req_write, funct3, addr, wdata, mem_dataout,
        output busy, done, fault, rdata, mem_raddress, mem_waddress, mem_datain, mem_wr
    );

    modport master (
        output req, req_write, funct3, addr, wdata, mem_dataout,
        input  busy, done, fault, rdata, mem_raddress, mem_waddress, mem_datain, mem_wr
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// Sequenced load/store engine for the 64-bit data memory: aligned little-endian
// accesses, read-modify-write for sub-doubleword stores, load extension, fault detection.
module data_mem_access_unit #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    data_mem_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, next;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic        fault_q;
    logic [2:0]  cnt;
    logic [63:0] rdata_q;
    logic [63:0] raddr_q;
    logic [63:0] waddr_q;
    logic [63:0] datain_q;
    logic        misaligned;
    logic        illegal;
    logic        acc_fault;
    logic        last_rd;

    function automatic logic [63:0] byte_mask(input logic [1:0] size);
        case (size)
            2'd0:    byte_mask = 64'h0000_0000_0000_00FF;
            2'd1:    byte_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    byte_mask = 64'h0000_0000_FFFF_FFFF;
            default: byte_mask = '1;
        endcase
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] line, input logic [63:0] data,
                                          input logic [2:0] off, input logic [1:0] size);
        logic [63:0] m;
        m = byte_mask(size) << {off, 3'b000};
        merge = (line & ~m) | ((data << {off, 3'b000}) & m);
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] line, input logic [2:0] off,
                                           input logic [2:0] f3);
        logic [63:0] s;
        s = line >> {off, 3'b000};
        case (f3[1:0])
            2'd0:    extend = f3[2] ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            2'd1:    extend = f3[2] ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            2'd2:    extend = f3[2] ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: extend = s;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (bus.funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.addr[0];
            2'd2:    misaligned = |bus.addr[1:0];
            default: misaligned = |bus.addr[2:0];
        endcase
    end

    assign illegal   = (bus.funct3 == 3'b111) | (bus.req_write & bus.funct3[2]);
    assign acc_fault = illegal | misaligned;
    assign last_rd   = (cnt == 3'd1);

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (acc_fault)
                        next = RESP;
                    else if (bus.req_write && bus.funct3[1:0] == 2'd3)
                        next = WR;
                    else
                        next = RD;
                end
            end
            RD:      if (last_rd) next = wr_q ? WR : RESP;
            WR:      next = RESP;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
            cnt      <= '0;
            rdata_q  <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            datain_q <= '0;
        end else begin
            state <= next;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        wr_q    <= bus.req_write;
                        f3_q    <= bus.funct3;
                        off_q   <= bus.addr[2:0];
                        wdata_q <= bus.wdata;
                        fault_q <= acc_fault;
                        cnt     <= 3'(READ_LAT);
                        // Faulting requests never touch the memory-side registers.
                        if (!acc_fault) begin
                            raddr_q <= {bus.addr[63:3], 3'b000};
                            waddr_q <= {bus.addr[63:3], 3'b000};
                            if (bus.req_write && bus.funct3[1:0] == 2'd3)
                                datain_q <= bus.wdata;
                        end
                    end
                end
                RD: begin
                    cnt <= cnt - 3'd1;
                    if (last_rd) begin
                        if (wr_q)
                            datain_q <= merge(bus.mem_dataout, wdata_q, off_q, f3_q[1:0]);
                        else
                            rdata_q <= extend(bus.mem_dataout, off_q, f3_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == RESP);
    assign bus.fault        = (state == RESP) & fault_q;
    assign bus.mem_wr       = (state == WR);
    assign bus.rdata        = rdata_q;
    assign bus.mem_raddress = raddr_q;
    assign bus.mem_waddress = waddr_q;
    assign bus.mem_datain   = datain_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: unit 0 at READ_LAT=1, unit 1 at READ_LAT=3, each with its own memory.
module tb_data_mem_access_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        req_s   [2];
    logic        wr_s    [2];
    logic [2:0]  f3_s    [2];
    logic [63:0] addr_s  [2];
    logic [63:0] wd_s    [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic        fault_o [2];
    logic        mwr_o   [2];
    logic [63:0] rdata_o [2];
    logic [63:0] wa_o    [2];
    logic [63:0] di_o    [2];

    logic [63:0] mem    [2][32];
    logic [7:0]  rbytes [2][256];
    logic [63:0] exp_rd [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : unit
        data_mem_access_unit_if bus ();
        logic [63:0] pipe [2];

        data_mem_access_unit #(.READ_LAT(g == 0 ? 1 : 3)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.req       = req_s[g];
        assign bus.req_write = wr_s[g];
        assign bus.funct3    = f3_s[g];
        assign bus.addr      = addr_s[g];
        assign bus.wdata     = wd_s[g];
        assign busy_o[g]     = bus.busy;
        assign done_o[g]     = bus.done;
        assign fault_o[g]    = bus.fault;
        assign mwr_o[g]      = bus.mem_wr;
        assign rdata_o[g]    = bus.rdata;
        assign wa_o[g]       = bus.mem_waddress;
        assign di_o[g]       = bus.mem_datain;

        always @(posedge clock) begin
            if (bus.mem_wr) mem[g][bus.mem_waddress[7:3]] <= bus.mem_datain;
            pipe[0] <= mem[g][bus.mem_raddress[7:3]];
            pipe[1] <= pipe[0];
        end
        // Latency 1: data valid in the cycle the address becomes stable; latency 3: two stages later.
        assign bus.mem_dataout = (g == 0) ? mem[g][bus.mem_raddress[7:3]] : pipe[1];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic preload(input int u, input logic [7:0] wa, input logic [63:0] v);
        int unsigned base;
        base = 32'(wa & 8'hF8);
        mem[u][wa[7:3]] = v;
        for (int unsigned i = 0; i < 8; i++) rbytes[u][base + i] = v[8*i +: 8];
    endtask

    // Issue one request and watch the unit until the cycle after done.
    task automatic do_op(input int u, input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic ef, input int ed, input logic [63:0] erd,
                         input int ewr, input logic [63:0] edi, input int extra, input string nm);
        int dcyc, wcyc, ndone, nwr, busy_bad;
        logic fseen;
        logic [63:0] rseen, waseen, diseen;
        dcyc = 0; wcyc = 0; ndone = 0; nwr = 0; busy_bad = 0;
        fseen = 1'bx; rseen = 'x; waseen = 'x; diseen = 'x;
        req_s[u] = 1'b1; wr_s[u] = w; f3_s[u] = f3; addr_s[u] = a; wd_s[u] = wd;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clock); #1;
            req_s[u] = (n == extra);
            if (mwr_o[u]) begin
                nwr++; wcyc = n; waseen = wa_o[u]; diseen = di_o[u];
            end
            if (done_o[u]) begin
                ndone++;
                if (dcyc == 0) begin
                    dcyc = n; fseen = fault_o[u]; rseen = rdata_o[u];
                end
            end
            if (dcyc == 0 || n == dcyc) begin
                if (!busy_o[u]) busy_bad++;
            end else begin
                if (busy_o[u]) busy_bad++;
                break;
            end
        end
        req_s[u] = 1'b0;
        chk({nm, ".done_cycle"}, 64'(dcyc), 64'(ed));
        chk({nm, ".done_count"}, 64'(ndone), 64'd1);
        chk({nm, ".fault"}, 64'(fseen), 64'(ef));
        chk({nm, ".rdata"}, rseen, erd);
        chk({nm, ".busy"}, 64'(busy_bad), 64'd0);
        chk({nm, ".wr_count"}, 64'(nwr), (ewr != 0) ? 64'd1 : 64'd0);
        if (ewr != 0) begin
            chk({nm, ".wr_cycle"}, 64'(wcyc), 64'(ewr));
            chk({nm, ".waddress"}, waseen, a & ~64'h7);
            chk({nm, ".datain"}, diseen, edi);
        end
    endtask

    // Reference model over a byte-addressed image of each memory.
    task automatic model(input int u, input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output logic ef, output int ed, output logic [63:0] erd,
                         output int ewr, output logic [63:0] edi);
        int unsigned nb, lo, base, lat;
        logic [63:0] v;
        nb  = 32'd1 << f3[1:0];
        lo  = 32'(a[7:0]);
        lat = (u == 0) ? 1 : 3;
        ef  = (f3 == 3'b111) || (w && f3[2]) || (lo % nb != 0);
        erd = exp_rd[u]; ewr = 0; edi = '0; ed = 1;
        if (!ef && w) begin
            for (int unsigned i = 0; i < nb; i++) rbytes[u][lo + i] = wd[8*i +: 8];
            base = lo - lo % 8;
            for (int unsigned i = 0; i < 8; i++) edi[8*i +: 8] = rbytes[u][base + i];
            ewr = (nb == 8) ? 1 : int'(lat) + 1;
            ed  = ewr + 1;
        end else if (!ef) begin
            v = '0;
            for (int unsigned i = 0; i < nb; i++) v[8*i +: 8] = rbytes[u][lo + i];
            if (!f3[2] && nb < 8 && v[8*nb - 1]) v = v | (~64'd0 << (8*nb));
            erd = v; exp_rd[u] = v;
            ed = int'(lat) + 1;
        end
    endtask

    typedef struct {
        int          u;
        logic        w;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] wd;
        logic        ef;
        int          ed;
        logic [63:0] erd;
        int          ewr;
        logic [63:0] edi;
        int          extra;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic ef;
        int ed, ewr;
        logic [63:0] erd, edi, a, wd;
        logic [2:0] f3;
        logic w;
        logic [7:0] lo;
        int unsigned nb;

        tbl[0]  = '{0, 1'b0, 3'b000, 64'h17, 64'h0, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FF88, 0, 64'h0, 0};
        tbl[1]  = '{0, 1'b0, 3'b100, 64'h17, 64'h0, 1'b0, 2, 64'h0000_0000_0000_0088, 0, 64'h0, 0};
        tbl[2]  = '{0, 1'b1, 3'b001, 64'h12, 64'h1234_ABCD, 1'b0, 3, 64'h88, 2, 64'h8877_6655_ABCD_2211, 0};
        tbl[3]  = '{0, 1'b0, 3'b001, 64'h12, 64'h0, 1'b0, 2, 64'hFFFF_FFFF_FFFF_ABCD, 0, 64'h0, 0};
        tbl[4]  = '{0, 1'b0, 3'b101, 64'h12, 64'h0, 1'b0, 2, 64'h0000_0000_0000_ABCD, 0, 64'h0, 0};
        tbl[5]  = '{0, 1'b0, 3'b110, 64'h14, 64'h0, 1'b0, 2, 64'h0000_0000_8877_6655, 0, 64'h0, 0};
        tbl[6]  = '{0, 1'b1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, 1'b0, 2, 64'h8877_6655, 1, 64'h0123_4567_89AB_CDEF, 0};
        tbl[7]  = '{0, 1'b0, 3'b011, 64'h18, 64'h0, 1'b0, 2, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 0};
        tbl[8]  = '{0, 1'b0, 3'b010, 64'h16, 64'h0, 1'b1, 1, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 0};
        tbl[9]  = '{0, 1'b0, 3'b111, 64'h10, 64'h0, 1'b1, 1, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 0};
        tbl[10] = '{0, 1'b1, 3'b100, 64'h10, 64'h55, 1'b1, 1, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 0};
        tbl[11] = '{0, 1'b1, 3'b010, 64'h1C, 64'hDEAD_BEEF, 1'b0, 3, 64'h0123_4567_89AB_CDEF, 2, 64'hDEAD_BEEF_89AB_CDEF, 0};
        tbl[12] = '{0, 1'b0, 3'b011, 64'h18, 64'h0, 1'b0, 2, 64'hDEAD_BEEF_89AB_CDEF, 0, 64'h0, 0};
        tbl[13] = '{0, 1'b1, 3'b000, 64'hFFFF_FFFF_FFFF_FFF8, 64'hAB, 1'b0, 3, 64'hDEAD_BEEF_89AB_CDEF, 2, 64'hAB, 0};
        tbl[14] = '{1, 1'b0, 3'b011, 64'h10, 64'h0, 1'b0, 4, 64'h8877_6655_4433_2211, 0, 64'h0, 2};
        tbl[15] = '{1, 1'b1, 3'b000, 64'h13, 64'hEE, 1'b0, 5, 64'h8877_6655_4433_2211, 4, 64'h8877_6655_EE33_2211, 0};
        tbl[16] = '{1, 1'b0, 3'b001, 64'h11, 64'h0, 1'b1, 1, 64'h8877_6655_4433_2211, 0, 64'h0, 0};

        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_s[u] = 1'b0; wr_s[u] = 1'b0; f3_s[u] = '0; addr_s[u] = '0; wd_s[u] = '0;
            for (int i = 0; i < 32; i++) mem[u][i] = '0;
            for (int i = 0; i < 256; i++) rbytes[u][i] = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset%0d.busy", u), 64'(busy_o[u]), 64'd0);
            chk($sformatf("reset%0d.done", u), 64'(done_o[u]), 64'd0);
            chk($sformatf("reset%0d.fault", u), 64'(fault_o[u]), 64'd0);
            chk($sformatf("reset%0d.mem_wr", u), 64'(mwr_o[u]), 64'd0);
            chk($sformatf("reset%0d.rdata", u), rdata_o[u], 64'd0);
            chk($sformatf("reset%0d.waddress", u), wa_o[u], 64'd0);
            chk($sformatf("reset%0d.datain", u), di_o[u], 64'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        preload(0, 8'h10, 64'h8877_6655_4433_2211);
        preload(1, 8'h10, 64'h8877_6655_4433_2211);
        for (int i = 0; i < 17; i++)
            do_op(tbl[i].u, tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].ef, tbl[i].ed,
                  tbl[i].erd, tbl[i].ewr, tbl[i].edi, tbl[i].extra, $sformatf("vec%0d", i));

        // Reset while a sub-doubleword store is still reading the line.
        preload(0, 8'h10, 64'h8877_6655_4433_2211);
        req_s[0] = 1'b1; wr_s[0] = 1'b1; f3_s[0] = 3'b010; addr_s[0] = 64'h14; wd_s[0] = 64'hCAFE_F00D;
        @(posedge clock); #1;
        req_s[0] = 1'b0;
        chk("rst_mid.busy_before", 64'(busy_o[0]), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid.busy", 64'(busy_o[0]), 64'd0);
        chk("rst_mid.done", 64'(done_o[0]), 64'd0);
        chk("rst_mid.mem_wr", 64'(mwr_o[0]), 64'd0);
        chk("rst_mid.rdata", rdata_o[0], 64'd0);
        @(posedge clock); #1;
        chk("rst_mid.mem_wr_held", 64'(mwr_o[0]), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_mid.busy_after", 64'(busy_o[0]), 64'd0);
        chk("rst_mid.memory", mem[0][2], 64'h8877_6655_4433_2211);
        do_op(0, 1'b0, 3'b010, 64'h14, 64'h0, 1'b0, 2, 64'hFFFF_FFFF_8877_6655, 0, 64'h0, 0, "rst_mid.lw");

        exp_rd[0] = 64'hFFFF_FFFF_8877_6655;
        exp_rd[1] = 64'h0;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 32; i++) preload(u, 8'(i * 8), {$urandom, $urandom});

        for (int k = 0; k < 120; k++) begin
            int u;
            u  = (k % 4 == 3) ? 1 : 0;
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            nb = 32'd1 << f3[1:0];
            lo = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) lo = lo & ~8'(nb - 1);
            a  = {$urandom, $urandom};
            a[7:0] = lo;
            model(u, w, f3, a, wd, ef, ed, erd, ewr, edi);
            do_op(u, w, f3, a, wd, ef, ed, erd, ewr, edi, 0, $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
